// File: rtl/cell_comm_packet_receiver.sv
// cell_comm_packet_receiver
// Parses 4-word cell-communication packets from the Aurora RX AXI stream
// and publishes each good packet's BPM index, X, Y, S and clipping flag
// as a one-cycle strobe. Malformed, truncated, over-length, stalled and
// CRC-flagged packets are counted with saturating 16-bit counters.
//
// Ports:
//   rxClk, rxResetN        receiver user clock, async active-low reset
//   rxValid/rxLast/rxData  input beat stream (no backpressure)
//   countersClear          synchronous clear of all counters
//   pkValid                one-cycle strobe, good packet published
//   pkIndex/pkX/pkY/pkS    published fields, held until the next good packet
//   pkClipping             clipping flag of the published packet
//   goodCount, headerErrCount, lengthErrCount, flaggedCount  saturating counters
module cell_comm_packet_receiver #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FOFB_IDX_WIDTH  = 9,
  parameter int unsigned WATCHDOG_CYCLES = 63
) (
  input  logic                      rxClk,
  input  logic                      rxResetN,
  input  logic                      rxValid,
  input  logic                      rxLast,
  input  logic [DATA_WIDTH-1:0]     rxData,
  input  logic                      countersClear,
  output logic                      pkValid,
  output logic [FOFB_IDX_WIDTH-1:0] pkIndex,
  output logic [31:0]               pkX,
  output logic [31:0]               pkY,
  output logic [31:0]               pkS,
  output logic                      pkClipping,
  output logic [15:0]               goodCount,
  output logic [15:0]               headerErrCount,
  output logic [15:0]               lengthErrCount,
  output logic [15:0]               flaggedCount
);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_X,
    ST_Y,
    ST_S,
    ST_DISCARD
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(WATCHDOG_CYCLES - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic [7:0]                wd_cnt;
  logic                      timeout;
  logic                      hdr_ok;
  logic                      latch_idx;
  logic                      latch_x;
  logic                      latch_y;
  logic                      publish;
  logic                      inc_hdr;
  logic                      inc_len;
  logic                      inc_flag;
  logic [FOFB_IDX_WIDTH-1:0] idx_q;
  logic [31:0]               x_q;
  logic [31:0]               y_q;

  // Padding bits between the index field and the magic must be zero.
  assign hdr_ok = (rxData[31:16] == 16'hA5BE) &&
                  ((rxData[15:0] >> FOFB_IDX_WIDTH) == 16'h0000);

  // Fires on the idle cycle that brings the idle count to WATCHDOG_CYCLES.
  assign timeout = (state != ST_HDR) && !rxValid && (wd_cnt == WD_LAST);

  always_ff @(posedge rxClk or negedge rxResetN) begin
    if (!rxResetN) state <= ST_HDR;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR: begin
        if (rxValid && !rxLast) state_nxt = hdr_ok ? ST_X : ST_DISCARD;
      end
      ST_X: begin
        if (timeout)      state_nxt = ST_HDR;
        else if (rxValid) state_nxt = rxLast ? ST_HDR : ST_Y;
      end
      ST_Y: begin
        if (timeout)      state_nxt = ST_HDR;
        else if (rxValid) state_nxt = rxLast ? ST_HDR : ST_S;
      end
      ST_S: begin
        if (timeout)      state_nxt = ST_HDR;
        else if (rxValid) state_nxt = rxLast ? ST_HDR : ST_DISCARD;
      end
      ST_DISCARD: begin
        if (timeout || (rxValid && rxLast)) state_nxt = ST_HDR;
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  always_comb begin
    latch_idx = 1'b0;
    latch_x   = 1'b0;
    latch_y   = 1'b0;
    publish   = 1'b0;
    inc_hdr   = 1'b0;
    inc_len   = 1'b0;
    inc_flag  = 1'b0;
    case (state)
      ST_HDR: begin
        if (rxValid) begin
          if (rxLast)      inc_len   = 1'b1;
          else if (hdr_ok) latch_idx = 1'b1;
          else             inc_hdr   = 1'b1;
        end
      end
      ST_X, ST_Y: begin
        if (timeout || (rxValid && rxLast)) inc_len = 1'b1;
        else if (rxValid) begin
          latch_x = (state == ST_X);
          latch_y = (state == ST_Y);
        end
      end
      ST_S: begin
        if (timeout) inc_len = 1'b1;
        else if (rxValid) begin
          if (!rxLast)        inc_len  = 1'b1;
          else if (rxData[31]) inc_flag = 1'b1;
          else                publish  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rxClk or negedge rxResetN) begin
    if (!rxResetN) begin
      wd_cnt <= '0;
    end else if (rxValid || state_nxt == ST_HDR) begin
      wd_cnt <= '0;
    end else if (state != ST_HDR) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  always_ff @(posedge rxClk or negedge rxResetN) begin
    if (!rxResetN) begin
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pkValid    <= 1'b0;
      pkIndex    <= '0;
      pkX        <= '0;
      pkY        <= '0;
      pkS        <= '0;
      pkClipping <= 1'b0;
    end else begin
      pkValid <= publish;
      if (latch_idx) idx_q <= rxData[FOFB_IDX_WIDTH-1:0];
      if (latch_x)   x_q   <= rxData[31:0];
      if (latch_y)   y_q   <= rxData[31:0];
      if (publish) begin
        pkIndex    <= idx_q;
        pkX        <= x_q;
        pkY        <= y_q;
        pkS        <= {{2{rxData[29]}}, rxData[29:0]};
        pkClipping <= rxData[30];
      end
    end
  end

  // Clear has priority over a coincident increment.
  function automatic logic [15:0] cnt_next(input logic [15:0] cnt,
                                           input logic inc,
                                           input logic clr);
    if (clr)                          return 16'h0000;
    else if (inc && cnt != 16'hFFFF)  return cnt + 16'd1;
    else                              return cnt;
  endfunction

  always_ff @(posedge rxClk or negedge rxResetN) begin
    if (!rxResetN) begin
      goodCount      <= '0;
      headerErrCount <= '0;
      lengthErrCount <= '0;
      flaggedCount   <= '0;
    end else begin
      goodCount      <= cnt_next(goodCount,      publish,  countersClear);
      headerErrCount <= cnt_next(headerErrCount, inc_hdr,  countersClear);
      lengthErrCount <= cnt_next(lengthErrCount, inc_len,  countersClear);
      flaggedCount   <= cnt_next(flaggedCount,   inc_flag, countersClear);
    end
  end

endmodule
